// File: rtl/vector_pkg.sv
// ============================================================================
// vector_pkg : shared types and codes for the vector display-list word format
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

package vector_pkg;

  localparam int VEC_COORD_W = 8;

  typedef struct packed {
    logic [VEC_COORD_W-1:0] x;
    logic [VEC_COORD_W-1:0] y;
    logic                   line;
    logic                   pos;
  } vec_word_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    LAUNCH = 3'd3,
    DRAW   = 3'd4,
    END    = 3'd5
  } player_state_t;

  localparam logic [1:0] CODE_SKIP = 2'b00;
  localparam logic [1:0] CODE_MOVE = 2'b01;
  localparam logic [1:0] CODE_LINE = 2'b10;
  localparam logic [1:0] CODE_END  = 2'b11;

  // Bit positions inside the one-hot kind vector {move, line, end, skip}.
  localparam int KIND_MOVE = 3;
  localparam int KIND_LINE = 2;
  localparam int KIND_END  = 1;
  localparam int KIND_SKIP = 0;

  function automatic logic [3:0] code_to_kind(input logic [1:0] code);
    logic [3:0] kind;
    kind = 4'b0000;
    case (code)
      CODE_MOVE: kind = 4'b1000;
      CODE_LINE: kind = 4'b0100;
      CODE_END:  kind = 4'b0010;
      default:   kind = 4'b0001;
    endcase
    return kind;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vector_word_decode.sv
// ============================================================================
// vector_word_decode : splits a display-list word into x, y and a one-hot kind
// Rev 1.0            : initial release
// ============================================================================
`default_nettype none

module vector_word_decode
  import vector_pkg::*;
#(
  parameter int OUT_WIDTH = 8
) (
  input  logic [2*OUT_WIDTH+1:0] word_i,
  output logic [OUT_WIDTH-1:0]   x_o,
  output logic [OUT_WIDTH-1:0]   y_o,
  output logic [3:0]             kind_o
);

  assign x_o    = word_i[2*OUT_WIDTH+1 -: OUT_WIDTH];
  assign y_o    = word_i[OUT_WIDTH+1 -: OUT_WIDTH];
  assign kind_o = code_to_kind(word_i[1:0]);

endmodule

`default_nettype wire

// File: rtl/vector_list_player.sv
// ============================================================================
// vector_list_player : replays the display-list RAM and issues line segments
//                      to the line drawer; VECTOR_LIST_POINT_EN draws 00 words
//                      as single dots.
// Rev 1.0            : initial release
// ============================================================================
`default_nettype none

module vector_list_player
  import vector_pkg::*;
#(
  parameter int OUT_WIDTH   = 8,
  parameter int ADR_WIDTH   = 16,
  parameter int DATAWIDTH   = 18,
  parameter int MAX_ENTRIES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  output logic                 halt,
  output logic [ADR_WIDTH-1:0] adrREAD,
  input  logic [DATAWIDTH-1:0] dataREAD,
  output logic [OUT_WIDTH-1:0] x0,
  output logic [OUT_WIDTH-1:0] y0,
  output logic [OUT_WIDTH-1:0] x1,
  output logic [OUT_WIDTH-1:0] y1,
  output logic                 start,
  input  logic                 busy,
  output logic [2:0]           state_debug
);

  localparam logic [ADR_WIDTH-1:0] LAST_ADR = ADR_WIDTH'(MAX_ENTRIES - 1);
  localparam logic [ADR_WIDTH-1:0] ADR_ONE  = ADR_WIDTH'(1);
`ifdef VECTOR_LIST_POINT_EN
  localparam bit POINT_EN = 1'b1;
`else
  localparam bit POINT_EN = 1'b0;
`endif

  player_state_t        state_q;
  logic [ADR_WIDTH-1:0] adr_q;
  logic [OUT_WIDTH-1:0] cur_x_q, cur_y_q;
  logic [OUT_WIDTH-1:0] x0_q, y0_q, x1_q, y1_q;
  logic                 start_q, halt_q;

  logic [OUT_WIDTH-1:0] word_x, word_y;
  logic [3:0]           word_kind;
  logic                 draw_word, at_last;
  logic [OUT_WIDTH-1:0] seg_x0, seg_y0;

  vector_word_decode #(
    .OUT_WIDTH (OUT_WIDTH)
  ) u_decode (
    .word_i (dataREAD[2*OUT_WIDTH+1:0]),
    .x_o    (word_x),
    .y_o    (word_y),
    .kind_o (word_kind)
  );

  assign at_last   = (adr_q == LAST_ADR);
  assign draw_word = word_kind[KIND_LINE] | (POINT_EN & word_kind[KIND_SKIP]);
  // A dot starts where it ends; a line starts at the current pen position.
  assign seg_x0    = word_kind[KIND_LINE] ? cur_x_q : word_x;
  assign seg_y0    = word_kind[KIND_LINE] ? cur_y_q : word_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      start_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      halt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          adr_q   <= '0;
          cur_x_q <= '0;
          cur_y_q <= '0;
          if (go) state_q <= FETCH;
        end
        FETCH: begin
          if (!go) begin
            adr_q   <= '0;
            state_q <= IDLE;
          end else begin
            state_q <= DECODE;
          end
        end
        DECODE: begin
          if (word_kind[KIND_END]) begin
            halt_q  <= 1'b1;
            state_q <= END;
          end else if (draw_word) begin
            x0_q    <= seg_x0;
            y0_q    <= seg_y0;
            x1_q    <= word_x;
            y1_q    <= word_y;
            cur_x_q <= word_x;
            cur_y_q <= word_y;
            start_q <= 1'b1;
            state_q <= LAUNCH;
          end else begin
            if (word_kind[KIND_MOVE]) begin
              cur_x_q <= word_x;
              cur_y_q <= word_y;
            end
            // The last allowed slot closes the pass even without an end marker.
            if (at_last) begin
              halt_q  <= 1'b1;
              state_q <= END;
            end else begin
              adr_q   <= adr_q + ADR_ONE;
              state_q <= FETCH;
            end
          end
        end
        LAUNCH: begin
          if (busy) begin
            start_q <= 1'b0;
            state_q <= DRAW;
          end
        end
        DRAW: begin
          if (!busy) begin
            if (at_last) begin
              halt_q  <= 1'b1;
              state_q <= END;
            end else begin
              adr_q   <= adr_q + ADR_ONE;
              state_q <= FETCH;
            end
          end
        end
        END: begin
          adr_q   <= '0;
          cur_x_q <= '0;
          cur_y_q <= '0;
          state_q <= go ? FETCH : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign halt        = halt_q;
  assign adrREAD     = adr_q;
  assign x0          = x0_q;
  assign y0          = y0_q;
  assign x1          = x1_q;
  assign y1          = y1_q;
  assign start       = start_q;
  assign state_debug = state_q;

endmodule

`default_nettype wire

// File: tb/tb_vector_list_player.sv
// ============================================================================
// tb_vector_list_player : directed bench with a RAM model and a line-drawer
//                         model for vector_list_player (MAX_ENTRIES = 4).
// Rev 1.0               : initial release
// ============================================================================
`default_nettype none

module tb_vector_list_player;
  import vector_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic        halt;
  logic [15:0] adrREAD;
  logic [17:0] dataREAD = '0;
  logic [7:0]  x0, y0, x1, y1;
  logic        start;
  logic        busy;
  logic [2:0]  state_debug;

  vector_list_player #(
    .OUT_WIDTH   (8),
    .ADR_WIDTH   (16),
    .DATAWIDTH   (18),
    .MAX_ENTRIES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .halt        (halt),
    .adrREAD     (adrREAD),
    .dataREAD    (dataREAD),
    .x0          (x0),
    .y0          (y0),
    .x1          (x1),
    .y1          (y1),
    .start       (start),
    .busy        (busy),
    .state_debug (state_debug)
  );

  always #5 clk = ~clk;

  logic [17:0] mem [0:15];
  always @(posedge clk) dataREAD <= mem[adrREAD[3:0]];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [17:0] w(input int x, input int y, input logic [1:0] c);
    return {8'(x), 8'(y), c};
  endfunction

  // Line-drawer model: acks ack_delay cycles after start, busy for busy_len.
  int          ack_delay = 1;
  int          busy_len  = 3;
  int          seg_cnt   = 0;
  logic [31:0] seg [0:7];
  logic [48:0] d_hold;
  bit          d_abort;

  initial begin
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if (start && !rst) begin
        d_hold = {start, x0, y0, x1, y1, adrREAD};
        if (seg_cnt < 8) seg[seg_cnt] = {x0, y0, x1, y1};
        seg_cnt++;
        d_abort = 1'b0;
        for (int i = 0; i < ack_delay && !d_abort; i++) begin
          @(negedge clk);
          if (rst) d_abort = 1'b1;
          else chk("launch_hold", {start, x0, y0, x1, y1, adrREAD}, d_hold);
        end
        if (!d_abort) begin
          busy = 1'b1;
          for (int i = 0; i < busy_len && !d_abort; i++) begin
            @(negedge clk);
            if (rst) d_abort = 1'b1;
            else chk("draw_hold", {start, adrREAD}, {1'b0, d_hold[15:0]});
          end
        end
        busy = 1'b0;
      end
    end
  end

  int          halt_cnt = 0;
  logic [15:0] halt_adr = '0;
  logic        halt_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (halt) begin
        chk("halt_one_cycle", halt_prev, 1'b0);
        halt_cnt++;
        halt_adr = adrREAD;
      end
      halt_prev = halt;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_halt(input int n, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (halt_cnt >= n) return;
      tick();
    end
    chk(tag, halt_cnt, n);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (state_debug == s) return;
      tick();
    end
    chk(tag, state_debug, s);
  endtask

  task automatic do_reset();
    go  = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = w(0, 0, CODE_END);
    seg_cnt  = 0;
    halt_cnt = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    go  = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = w(0, 0, CODE_END);
    repeat (3) tick();
    chk("rst_start", start, 1'b0);
    chk("rst_halt", halt, 1'b0);
    chk("rst_adr", adrREAD, 16'd0);
    chk("rst_coords", {x0, y0, x1, y1}, 32'd0);
    chk("rst_state", state_debug, 3'(IDLE));

    // Single move + line, continuous replay.
    do_reset();
    mem[0] = w(0, 0, CODE_MOVE);
    mem[1] = w(10, 20, CODE_LINE);
    mem[2] = w(0, 0, CODE_END);
    ack_delay = 1; busy_len = 5; go = 1'b1;
    wait_halt(1, 100, "t1_halt_timeout");
    chk("t1_halt_adr", halt_adr, 16'd2);
    chk("t1_seg_cnt", seg_cnt, 1);
    chk("t1_seg", seg[0], {8'd0, 8'd0, 8'd10, 8'd20});
    tick();
    chk("t1_replay", {state_debug, adrREAD}, {3'(FETCH), 16'd0});
    wait_halt(2, 100, "t1_halt2_timeout");
    go = 1'b0;
    chk("t1_seg_cnt2", seg_cnt, 2);
    chk("t1_seg2", seg[1], {8'd0, 8'd0, 8'd10, 8'd20});
    wait_state(3'(IDLE), 20, "t1_idle_timeout");
    chk("t1_idle_adr", adrREAD, 16'd0);

    // Two chained lines: pen position carries across.
    do_reset();
    mem[0] = w(5, 5, CODE_MOVE);
    mem[1] = w(9, 5, CODE_LINE);
    mem[2] = w(9, 9, CODE_LINE);
    mem[3] = w(0, 0, CODE_END);
    ack_delay = 1; busy_len = 3; go = 1'b1;
    wait_halt(1, 100, "t2_halt_timeout");
    go = 1'b0;
    chk("t2_seg_cnt", seg_cnt, 2);
    chk("t2_seg0", seg[0], {8'd5, 8'd5, 8'd9, 8'd5});
    chk("t2_seg1", seg[1], {8'd9, 8'd5, 8'd9, 8'd9});
    tick();
    chk("t2_idle", state_debug, 3'(IDLE));

    // Slow ack: start and coordinates must hold, pen starts at origin.
    do_reset();
    mem[0] = w(3, 4, CODE_LINE);
    mem[1] = w(0, 0, CODE_END);
    ack_delay = 7; busy_len = 2; go = 1'b1;
    wait_halt(1, 100, "t3_halt_timeout");
    go = 1'b0;
    chk("t3_seg_cnt", seg_cnt, 1);
    chk("t3_seg", seg[0], {8'd0, 8'd0, 8'd3, 8'd4});
    chk("t3_halt_adr", halt_adr, 16'd1);

    // go dropped during DRAW: segment finishes, then IDLE without halt.
    do_reset();
    mem[0] = w(1, 1, CODE_MOVE);
    mem[1] = w(2, 2, CODE_LINE);
    mem[2] = w(3, 3, CODE_LINE);
    mem[3] = w(0, 0, CODE_END);
    ack_delay = 1; busy_len = 4; go = 1'b1;
    wait_state(3'(DRAW), 50, "t4_draw_timeout");
    go = 1'b0;
    wait_state(3'(IDLE), 50, "t4_idle_timeout");
    repeat (10) tick();
    chk("t4_seg_cnt", seg_cnt, 1);
    chk("t4_seg", seg[0], {8'd1, 8'd1, 8'd2, 8'd2});
    chk("t4_no_halt", halt_cnt, 0);
    chk("t4_state", {state_debug, adrREAD}, {3'(IDLE), 16'd0});

    // No end marker: the watchdog closes the pass at address 3.
    do_reset();
    mem[0] = w(1, 2, CODE_MOVE);
    mem[1] = w(3, 4, CODE_MOVE);
    mem[2] = w(5, 6, CODE_MOVE);
    mem[3] = w(7, 8, CODE_MOVE);
    mem[4] = w(9, 9, CODE_LINE);
    ack_delay = 1; busy_len = 2; go = 1'b1;
    wait_halt(1, 100, "t5_halt_timeout");
    go = 1'b0;
    chk("t5_halt_adr", halt_adr, 16'd3);
    tick();
    chk("t5_seg_cnt", seg_cnt, 0);
    chk("t5_idle", state_debug, 3'(IDLE));

    // 00 word: dot when the point feature is built in, ignored otherwise.
    do_reset();
    mem[0] = w(7, 8, CODE_SKIP);
    mem[1] = w(0, 0, CODE_END);
    ack_delay = 1; busy_len = 2; go = 1'b1;
    wait_halt(1, 100, "t6_halt_timeout");
    go = 1'b0;
`ifdef VECTOR_LIST_POINT_EN
    chk("t6_seg_cnt", seg_cnt, 1);
    chk("t6_dot", seg[0], {8'd7, 8'd8, 8'd7, 8'd8});
`else
    chk("t6_seg_cnt", seg_cnt, 0);
`endif

    // Reset while waiting in LAUNCH.
    do_reset();
    mem[0] = w(4, 4, CODE_LINE);
    mem[1] = w(0, 0, CODE_END);
    ack_delay = 50; busy_len = 2; go = 1'b1;
    wait_state(3'(LAUNCH), 50, "t7_launch_timeout");
    chk("t7_launch_start", {start, x1, y1}, {1'b1, 8'd4, 8'd4});
    rst = 1'b1;
    tick();
    chk("t7_rst_start", start, 1'b0);
    chk("t7_rst_all", {halt, adrREAD, x0, y0, x1, y1, state_debug}, 52'd0);
    rst = 1'b0;
    go  = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vector_list_player.md
Name: vector_list_player

Overview:
- Downstream consumer of the display-list RAM filled by the frame-building stage.
- Replays the RAM word by word and decodes each 18-bit vector word {x[17:10], y[9:2], line[1], pos[0]}.
- Issues segment requests (x0,y0)->(x1,y1) to the bresenham line drawer over a req/ack handshake.
- Pulses halt to the frame-building stage after each complete pass so it can rebuild the list.

Parameters:
- OUT_WIDTH, 8, coordinate width.
- ADR_WIDTH, 16, RAM address width.
- DATAWIDTH, 18, vector word width; must equal 2*OUT_WIDTH+2.
- MAX_ENTRIES, 1024, maximum words read per pass; acts as a watchdog when no end marker is present.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- go  in  1  list complete and stable; level input.
- halt  out  1  one-cycle pulse at end of each pass.
- adrREAD  out  ADR_WIDTH  RAM read address.
- dataREAD  in  DATAWIDTH  RAM read data; valid one cycle after adrREAD.
- x0  out  OUT_WIDTH  segment start x.
- y0  out  OUT_WIDTH  segment start y.
- x1  out  OUT_WIDTH  segment end x.
- y1  out  OUT_WIDTH  segment end y.
- start  out  1  segment request.
- busy  in  1  line drawer busy / acknowledge.
- state_debug  out  3  current state encoding.

Behaviour:
- One clock domain, clk only. Reset is synchronous and active-high.
- Reset values: all outputs 0; cur_x/cur_y 0; state IDLE. Reset mid-segment drops start the next cycle; the line drawer is not told to abort.
- Word decode, {line,pos}:
  - 01 move-to: cur := (x,y); nothing drawn.
  - 10 line-to: draw segment cur->(x,y), then cur := (x,y).
  - 00 ignored (see optional feature).
  - 11 end of list.
- IDLE: adrREAD=0. If go=1, go to FETCH.
- FETCH: adrREAD stable for 1 cycle, then go to DECODE (1-cycle RAM latency).
- DECODE:
  - move: update cur; adrREAD+1; go to FETCH.
  - line: x0,y0 := cur; x1,y1 := word x,y; start := 1; cur := word; go to LAUNCH.
  - end: go to END.
  - 00: adrREAD+1; go to FETCH.
  - If adrREAD == MAX_ENTRIES-1 and the word is not end, treat it as end after processing it.
- LAUNCH: hold start=1 and the coordinates stable until busy=1 is sampled. Then start := 0; go to DRAW.
- DRAW: wait for busy=0. Then adrREAD+1; go to FETCH.
- END: halt=1 for exactly this cycle; adrREAD := 0. Next state is FETCH if go=1 (continuous replay), else IDLE.
- go dropping mid-pass: the current segment completes (LAUNCH/DRAW are never abandoned). At the next FETCH entry with go=0, go to IDLE with no halt pulse.
- Timing: coordinates are registered. Minimum of 2 cycles per move word and 4 + drawer time per line word.
- No arithmetic on coordinates; values pass through unchanged. Address increments are modulo 2^ADR_WIDTH, bounded by MAX_ENTRIES.
- First line-to of a pass with no preceding move-to starts from cur=(0,0). cur resets to (0,0) at each pass start.

Optional Feature:
- Macro: VECTOR_LIST_POINT_EN.
- Defined: a {line,pos}=00 word draws a zero-length segment (x0=x1=x, y0=y1=y) through LAUNCH/DRAW as a single dot, and sets cur := (x,y).
- Undefined: 00 words are skipped with no effect on cur or on start.

Decomposition:
- vector_pkg holds:
  - typedef vec_word_t (packed struct x, y, line, pos);
  - enum player_state_t {IDLE, FETCH, DECODE, LAUNCH, DRAW, END};
  - localparam codes CODE_MOVE=2'b01, CODE_LINE=2'b10, CODE_END=2'b11, CODE_SKIP=2'b00.
- Sub-module vector_word_decode: combinational split of dataREAD into x, y and a one-hot kind {move, line, end, skip}. Shared with future stages.

Test Plan:
- RAM = [(0,0,01),(10,20,10),(0,0,11)], go=1, drawer acks 1 cycle after start and stays busy 5 cycles -> one start with x0,y0=0,0 and x1,y1=10,20; halt pulses once; adrREAD returns to 0 and replays.
- RAM = [(5,5,01),(9,5,10),(9,9,10),(0,0,11)] -> two segments in order: (5,5)->(9,5), then (9,5)->(9,9); cur carried correctly between them.
- busy held 0 for 7 cycles after start -> start and coordinates remain stable for all 7 cycles; no address advance until busy rises and then falls.
- go dropped while in DRAW of segment 1 -> segment completes, no further start, state IDLE, no halt pulse.
- MAX_ENTRIES=4, RAM of four move words with no end marker -> halt pulses after adrREAD=3; rst asserted mid-LAUNCH -> start=0 and all outputs 0 next cycle.
- VECTOR_LIST_POINT_EN defined, word (7,8,00) -> a segment with x0=x1=7 and y0=y1=8; undefined -> no start issued for that word.
